my_fetch16: RTL
===============

# my_fetch16

Instruction-fetch stage for the 16-bit CPU; sits directly upstream of the `my_CPU16v0` datapath and drives its `IR` input.
- Holds the program counter and requests words from instruction memory over a req/ack handshake.
- Captures each returned word into an instruction register and presents it to the datapath with a valid/ready handshake.
- Supports branch redirect and a halt opcode.

## Interface
Parameters:
- `PC_W`, 16, program-counter and memory-address width.
- `RESET_PC`, 16'h0000, first fetch address after reset.

Ports:
- `CK`  in  1  clock, rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  PC_W  fetch address (the current fetch PC).
- `imem_ack`  in  1  memory response; `imem_data` is valid in the same cycle.
- `imem_data`  in  16  instruction word.
- `ir`  out  16  instruction register to the datapath.
- `ir_valid`  out  1  `ir` holds an unconsumed instruction.
- `ir_ready`  in  1  datapath accepts `ir` at this edge.
- `pc`  out  PC_W  address of the word currently in `ir`.
- `redirect`  in  1  branch/jump taken.
- `redirect_pc`  in  PC_W  branch target.
- `halt`  out  1  halt opcode has been consumed; fetch stopped.

## Operation
- Internal state: `fpc` (fetch PC); FSM states IDLE, FETCH, HOLD, HALT.
- IDLE: `imem_req`=0. Goes to FETCH on the next edge unconditionally.
- FETCH: `imem_req`=1, `imem_addr`=`fpc`. At an edge with `imem_ack`=1:
  - `ir`<=`imem_data`, `pc`<=`fpc`, `fpc`<=`fpc`+1.
  - Next state HOLD.
- HOLD: `ir_valid`=1, `imem_req`=0. At an edge with `ir_ready`=1:
  - If `ir`==16'hFFFF (halt opcode), go to HALT.
  - Otherwise go to FETCH.
- HALT: `imem_req`=0, `ir_valid`=0, `halt`=1. Leaves HALT only by reset or redirect.
- Redirect: in any state, an edge with `redirect`=1 does all of the following:
  - `fpc`<=`redirect_pc`; next state FETCH; `halt`<=0.
  - Any `imem_ack` in the same cycle is discarded: `ir` and `pc` are unchanged, and `ir_valid` drops next cycle.
  - Redirect has priority over both `imem_ack` and `ir_ready`.
- Arithmetic: `fpc` increments modulo 2^PC_W, so 16'hFFFF wraps to 16'h0000 with no flag.
- `imem_ack` is ignored outside FETCH. `ir_ready` is ignored outside HOLD.
- `ir` and `pc` keep their value after consumption until the next capture.

## Timing
- Reset (async, immediate) forces:
  - state IDLE, `fpc`=RESET_PC, `imem_addr`=RESET_PC.
  - `imem_req`=0, `ir`=0, `ir_valid`=0, `pc`=0, `halt`=0.
- First `imem_req` is asserted in the cycle after the first edge following reset release.
- Latency with zero-wait memory (`imem_ack` high in the first FETCH cycle):
  - `ir_valid` rises one cycle after `imem_req`.
  - Sustained throughput is 1 instruction per 2 cycles when `ir_ready` is held high.
- Each memory wait cycle (`imem_ack`=0) adds one cycle. Each cycle with `ir_ready` low in HOLD adds one cycle.
- Reset asserted mid-FETCH or mid-HOLD abandons the transaction; the outstanding ack and `ir` are lost.
- All outputs are registered or decoded from the state only; there is no combinational path from inputs to outputs.

## Configuration
- `FETCH_PERF_EN` defined: adds port `stall_cnt`  out  16.
  - Counts edges in FETCH with `imem_ack`=0.
  - Saturates at 16'hFFFF; reset to 0; unaffected by redirect.
- `FETCH_PERF_EN` undefined: no `stall_cnt` port and no counter logic; behaviour is otherwise identical.

## Test plan
- Reset release, memory returns 16'h00A1 at address 0 with zero wait, `ir_ready`=1:
  - `imem_req` in cycle 1; `ir`=16'h00A1, `pc`=0, `ir_valid`=1 in cycle 2.
  - Next request goes to address 1 in cycle 3.
- 3-cycle memory wait, then `ir_ready` low for 2 cycles:
  - `ir_valid` holds with `ir` stable.
  - `imem_req` stays 0 until the consume edge.
  - With `FETCH_PERF_EN`, `stall_cnt`=3.
- `redirect`=1, `redirect_pc`=16'h0040 in the same cycle as `imem_ack`:
  - Acked word is discarded; `ir`/`pc` unchanged; `ir_valid` drops.
  - Next `imem_addr`=16'h0040.
- Fetch at `fpc`=16'hFFFF, consumed:
  - `pc`=16'hFFFF; next `imem_addr`=16'h0000.
- Memory returns 16'hFFFF, consumed:
  - `halt`=1 and `imem_req`=0 for 10 cycles.
  - `redirect` to 16'h0010 clears `halt` and fetches address 16'h0010.
- `RST` pulsed mid-HOLD (not aligned to `CK`):
  - All outputs take their reset values immediately.
  - Fetch restarts at RESET_PC.

Source files
------------

// File: rtl/my_fetch16.sv
// Instruction-fetch stage: PC, imem req/ack, instruction register with valid/ready to the datapath.
// Optional stall counter enabled by defining FETCH_PERF_EN.
module my_fetch16 #(
  parameter int unsigned       PC_W     = 16,
  parameter logic [PC_W-1:0]   RESET_PC = '0
) (
  input  logic            CK,
  input  logic            RST,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  output logic [15:0]     ir,
  output logic            ir_valid,
  input  logic            ir_ready,
  output logic [PC_W-1:0] pc,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            halt
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]     stall_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_HALT
  } state_t;

  localparam logic [15:0] HALT_OP = 16'hFFFF;

  state_t          state;
  state_t          state_nxt;
  logic [PC_W-1:0] fpc;

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Redirect overrides every state, including a pending ack or consume.
  always_comb begin
    state_nxt = state;
    if (redirect) begin
      state_nxt = S_FETCH;
    end else begin
      case (state)
        S_IDLE:  state_nxt = S_FETCH;
        S_FETCH: if (imem_ack) state_nxt = S_HOLD;
        S_HOLD:  if (ir_ready) state_nxt = (ir == HALT_OP) ? S_HALT : S_FETCH;
        S_HALT:  state_nxt = S_HALT;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    imem_req = (state == S_FETCH);
    ir_valid = (state == S_HOLD);
    halt     = (state == S_HALT);
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      fpc <= RESET_PC;
      ir  <= '0;
      pc  <= '0;
    end else if (redirect) begin
      fpc <= redirect_pc;
    end else if ((state == S_FETCH) && imem_ack) begin
      ir  <= imem_data;
      pc  <= fpc;
      fpc <= fpc + PC_W'(1);
    end
  end

  assign imem_addr = fpc;

`ifdef FETCH_PERF_EN
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      stall_cnt <= '0;
    end else if ((state == S_FETCH) && !imem_ack && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
